// File: rtl/synth_midi_pkg.sv
// Shared types and constants for the synth MIDI output path: event types,
// status nibbles, transmit FSM states and message-length helpers.
package synth_midi_pkg;

  typedef enum logic [2:0] {
    EV_NOTE_OFF = 3'd0,
    EV_NOTE_ON  = 3'd1,
    EV_POLY_AT  = 3'd2,
    EV_CTRL     = 3'd3,
    EV_PRG      = 3'd4,
    EV_CH_AT    = 3'd5,
    EV_PITCH    = 3'd6,
    EV_ILLEGAL  = 3'd7
  } ev_type_e;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PRG      = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STAT = 3'd1,
    ST_D1   = 3'd2,
    ST_D2   = 3'd3,
    ST_GAP  = 3'd4
  } tx_state_e;

  // Program change and channel aftertouch carry a single data byte.
  function automatic logic [1:0] msg_len(input ev_type_e t);
    return ((t == EV_PRG) || (t == EV_CH_AT)) ? 2'd2 : 2'd3;
  endfunction

  function automatic logic [3:0] status_nibble(input ev_type_e t);
    case (t)
      EV_NOTE_OFF: return NOTE_OFF;
      EV_NOTE_ON:  return NOTE_ON;
      EV_POLY_AT:  return POLY_AT;
      EV_CTRL:     return CTRL;
      EV_PRG:      return PRG;
      EV_CH_AT:    return CH_AT;
      EV_PITCH:    return PITCH;
      default:     return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/midi_rs_timer.sv
// Saturating idle counter: cleared on every transmitted byte, reports when
// the line has been quiet long enough that running status must be dropped.
module midi_rs_timer #(
  parameter int RS_TIMEOUT = 5_000_000,
  parameter int RS_W       = 23
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_expired
);

  localparam logic [RS_W-1:0] LP_LIMIT = RS_W'(RS_TIMEOUT);

  logic [RS_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != LP_LIMIT) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LP_LIMIT);

endmodule

// File: rtl/midi_event_tx.sv
// Turns synth channel events into a MIDI byte stream for the UART transmitter,
// with optional running status and note-off-as-velocity-0 compression.
module midi_event_tx
  import synth_midi_pkg::*;
#(
  parameter int RS_TIMEOUT      = 5_000_000,
  parameter int RS_W            = 23,
  parameter bit NOTEOFF_AS_VEL0 = 1'b1
) (
  input  logic       data_clk,
  input  logic       reset_reg_N,
  input  logic [3:0] midi_ch,
  input  logic       rs_enable,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [2:0] ev_type,
  input  logic [6:0] ev_data1,
  input  logic [6:0] ev_data2,
  input  logic       midi_out_ready,
  output logic       midi_send_byte,
  output logic [7:0] midi_out_data,
  output logic       busy,
  output logic       drop_err
);

  tx_state_e  r_state;
  tx_state_e  w_next;

  logic [7:0] r_status;
  logic [6:0] r_d1;
  logic [6:0] r_d2;
  logic       r_len3;
  logic       r_rs_en;
  logic [1:0] r_last_sent;
  logic [7:0] r_last_status;
  logic       r_last_valid;
  logic       r_ev_ready;
  logic       r_drop_err;

  logic       w_accept;
  logic       w_illegal;
  logic       w_rewrite;
  logic [7:0] w_status;
  logic       w_skip;
  logic       w_send;
  logic [7:0] w_byte;
  logic       w_expired;

  assign w_accept  = ev_valid && r_ev_ready;
  assign w_illegal = (ev_type_e'(ev_type) == EV_ILLEGAL);
  assign w_rewrite = NOTEOFF_AS_VEL0 && rs_enable && (ev_type_e'(ev_type) == EV_NOTE_OFF);
  assign w_status  = {(w_rewrite ? NOTE_ON : status_nibble(ev_type_e'(ev_type))), midi_ch};
  assign w_skip    = rs_enable && r_last_valid && (r_last_status == w_status) && !w_expired;

  midi_rs_timer #(
    .RS_TIMEOUT (RS_TIMEOUT),
    .RS_W       (RS_W)
  ) u_rs_timer (
    .i_clk     (data_clk),
    .i_rst_n   (reset_reg_N),
    .i_clear   (w_send),
    .o_expired (w_expired)
  );

  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Each byte state waits for the UART, then always passes through one GAP
  // cycle so the UART has time to drop its ready before the next byte.
  always_comb begin
    w_next = r_state;
    w_send = 1'b0;
    w_byte = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_illegal) begin
          w_next = w_skip ? ST_D1 : ST_STAT;
        end
      end
      ST_STAT: begin
        w_byte = r_status;
        if (midi_out_ready) begin
          w_send = 1'b1;
          w_next = ST_GAP;
        end
      end
      ST_D1: begin
        w_byte = {1'b0, r_d1};
        if (midi_out_ready) begin
          w_send = 1'b1;
          w_next = ST_GAP;
        end
      end
      ST_D2: begin
        w_byte = {1'b0, r_d2};
        if (midi_out_ready) begin
          w_send = 1'b1;
          w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_last_sent == 2'd0) begin
          w_next = ST_D1;
        end else if ((r_last_sent == 2'd1) && r_len3) begin
          w_next = ST_D2;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_status    <= 8'h00;
      r_d1        <= 7'h00;
      r_d2        <= 7'h00;
      r_len3      <= 1'b0;
      r_rs_en     <= 1'b0;
      r_last_sent <= 2'd0;
      r_ev_ready  <= 1'b1;
      r_drop_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_status <= w_status;
        r_d1     <= ev_data1;
        r_d2     <= w_rewrite ? 7'h00 : ev_data2;
        r_len3   <= (msg_len(ev_type_e'(ev_type)) == 2'd3);
        r_rs_en  <= rs_enable;
      end
      if (w_send) begin
        r_last_sent <= (r_state == ST_D1) ? 2'd1 : ((r_state == ST_D2) ? 2'd2 : 2'd0);
      end
      r_ev_ready <= (w_next == ST_IDLE) && !w_accept;
      r_drop_err <= w_accept && w_illegal;
    end
  end

  // A freshly sent status wins over invalidation so a status sent just as the
  // timer saturates still becomes the running status.
  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_last_status <= 8'h00;
      r_last_valid  <= 1'b0;
    end else if (w_send && (r_state == ST_STAT) && r_rs_en) begin
      r_last_status <= r_status;
      r_last_valid  <= 1'b1;
    end else if (!rs_enable || w_expired) begin
      r_last_valid  <= 1'b0;
    end
  end

  assign ev_ready       = r_ev_ready;
  assign midi_send_byte = w_send;
  assign midi_out_data  = w_byte;
  assign busy           = (r_state != ST_IDLE);
  assign drop_err       = r_drop_err;

endmodule

// File: tb/tb_midi_event_tx.sv
// Directed bench for midi_event_tx: UART ready model plus byte capture, with
// hand-computed byte streams and timing for each scenario.
module tb_midi_event_tx;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [3:0] midiCh = 4'h0;
  logic       rsEnable = 1'b0;
  logic       evValid = 1'b0;
  logic [2:0] evType = 3'd0;
  logic [6:0] evData1 = 7'h00;
  logic [6:0] evData2 = 7'h00;
  logic       holdLow = 1'b0;

  logic       evReady, sendByte, busy, dropErr;
  logic [7:0] outData;
  logic       evReady0, sendByte0, busy0, dropErr0;
  logic [7:0] outData0;
  logic       rdy1 = 1'b1;
  logic       rdy0 = 1'b1;
  int         cnt1 = 0;
  int         cnt0 = 0;
  logic       sent1 = 1'b0;
  logic       sent0 = 1'b0;

  int   cyc = 0;
  int   nAsserts = 0;
  int   nFail = 0;
  bq_t  q1;
  bq_t  q0;
  int   c1[$];
  int   acceptCyc;
  logic readyAtN1, dropAtN1, busyAtN1;
  int   readyCyc;
  bq_t  expQ;

  midi_event_tx #(.RS_TIMEOUT(16), .RS_W(5), .NOTEOFF_AS_VEL0(1'b1)) u_dut (
    .data_clk(clk), .reset_reg_N(rstN), .midi_ch(midiCh), .rs_enable(rsEnable),
    .ev_valid(evValid), .ev_ready(evReady), .ev_type(evType), .ev_data1(evData1),
    .ev_data2(evData2), .midi_out_ready(rdy1), .midi_send_byte(sendByte),
    .midi_out_data(outData), .busy(busy), .drop_err(dropErr)
  );

  midi_event_tx #(.RS_TIMEOUT(16), .RS_W(5), .NOTEOFF_AS_VEL0(1'b0)) u_dut0 (
    .data_clk(clk), .reset_reg_N(rstN), .midi_ch(midiCh), .rs_enable(rsEnable),
    .ev_valid(evValid), .ev_ready(evReady0), .ev_type(evType), .ev_data1(evData1),
    .ev_data2(evData2), .midi_out_ready(rdy0), .midi_send_byte(sendByte0),
    .midi_out_data(outData0), .busy(busy0), .drop_err(dropErr0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    sent1 = sendByte;
    sent0 = sendByte0;
    if (sendByte) begin
      q1.push_back(outData);
      c1.push_back(cyc);
    end
    if (sendByte0) q0.push_back(outData0);
  end

  // UART model: ready falls the cycle after a send and returns 3 cycles later.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdy1 <= 1'b1; cnt1 <= 0;
    end else if (holdLow) begin
      rdy1 <= 1'b0;
    end else if (sent1) begin
      rdy1 <= 1'b0; cnt1 <= 3;
    end else if (cnt1 != 0) begin
      cnt1 <= cnt1 - 1;
      if (cnt1 == 1) rdy1 <= 1'b1;
    end else begin
      rdy1 <= 1'b1;
    end
  end

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdy0 <= 1'b1; cnt0 <= 0;
    end else if (holdLow) begin
      rdy0 <= 1'b0;
    end else if (sent0) begin
      rdy0 <= 1'b0; cnt0 <= 3;
    end else if (cnt0 != 0) begin
      cnt0 <= cnt0 - 1;
      if (cnt0 == 1) rdy0 <= 1'b1;
    end else begin
      rdy0 <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBytes(input string tag, input bq_t got, input bq_t exp);
    checkOutput({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      checkOutput($sformatf("%s_b%0d", tag, i), got[i], exp[i]);
  endtask

  // Offer one event, wait for acceptance, and return at the negedge of cycle N+1.
  task automatic applyStimulus(input logic [2:0] t, input logic [6:0] d1, input logic [6:0] d2,
                               input logic [3:0] ch, input logic rs);
    int waitCnt;
    @(negedge clk);
    evType = t; evData1 = d1; evData2 = d2; midiCh = ch; rsEnable = rs; evValid = 1'b1;
    waitCnt = 0;
    while (!evReady && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("accept_bound", (waitCnt < 100), 1);
    @(negedge clk);
    acceptCyc = cyc;
    readyAtN1 = evReady;
    dropAtN1  = dropErr;
    busyAtN1  = busy;
    evValid   = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(evReady && !busy && !busy0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    readyCyc = cyc;
    checkOutput("idle_bound", (n < 200), 1);
  endtask

  task automatic clearQueues();
    q1.delete(); q0.delete(); c1.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_ev_ready", evReady, 1);
    checkOutput("rst_send", sendByte, 0);
    checkOutput("rst_data", outData, 8'h00);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_drop", dropErr, 0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] noteon without running status");
    clearQueues();
    applyStimulus(3'd1, 7'd60, 7'd100, 4'd2, 1'b0);
    midiCh = 4'd5;
    checkOutput("t1_ready_n1", readyAtN1, 0);
    waitIdle();
    expQ = '{8'h92, 8'h3C, 8'h64};
    checkBytes("t1", q1, expQ);
    if (c1.size() == 3) begin
      checkOutput("t1_first_pulse", c1[0] - acceptCyc, 0);
      checkOutput("t1_second_pulse", c1[1] - acceptCyc, 4);
      checkOutput("t1_third_pulse", c1[2] - acceptCyc, 8);
    end
    checkOutput("t1_ready_back", readyCyc - acceptCyc, 10);

    $display("[TB] running status back-to-back");
    clearQueues();
    applyStimulus(3'd1, 7'd60, 7'd100, 4'd2, 1'b1);
    applyStimulus(3'd1, 7'd62, 7'd100, 4'd2, 1'b1);
    waitIdle();
    expQ = '{8'h92, 8'h3C, 8'h64, 8'h3E, 8'h64};
    checkBytes("t2", q1, expQ);

    $display("[TB] noteoff rewrite");
    @(negedge clk);
    rsEnable = 1'b0;
    @(negedge clk);
    clearQueues();
    applyStimulus(3'd1, 7'd60, 7'd100, 4'd2, 1'b1);
    applyStimulus(3'd0, 7'd60, 7'd40, 4'd2, 1'b1);
    waitIdle();
    expQ = '{8'h92, 8'h3C, 8'h64, 8'h3C, 8'h00};
    checkBytes("t3_vel0", q1, expQ);
    expQ = '{8'h92, 8'h3C, 8'h64, 8'h82, 8'h3C, 8'h28};
    checkBytes("t3_noteoff", q0, expQ);

    $display("[TB] program, pitch, illegal");
    clearQueues();
    applyStimulus(3'd4, 7'd5, 7'h7F, 4'd0, 1'b0);
    waitIdle();
    applyStimulus(3'd6, 7'h00, 7'h40, 4'd0, 1'b0);
    waitIdle();
    expQ = '{8'hC0, 8'h05, 8'hE0, 8'h00, 8'h40};
    checkBytes("t4", q1, expQ);
    clearQueues();
    applyStimulus(3'd7, 7'h11, 7'h22, 4'd0, 1'b0);
    checkOutput("t4_drop_n1", dropAtN1, 1);
    checkOutput("t4_busy_n1", busyAtN1, 0);
    @(negedge clk);
    checkOutput("t4_drop_n2", dropErr, 0);
    repeat (6) @(negedge clk);
    checkOutput("t4_no_bytes", q1.size(), 0);
    checkOutput("t4_ready", evReady, 1);

    $display("[TB] running status timeout");
    clearQueues();
    applyStimulus(3'd1, 7'd60, 7'd100, 4'd0, 1'b1);
    waitIdle();
    repeat (20) @(negedge clk);
    applyStimulus(3'd1, 7'd60, 7'd100, 4'd0, 1'b1);
    waitIdle();
    repeat (10) @(negedge clk);
    applyStimulus(3'd1, 7'd60, 7'd100, 4'd0, 1'b1);
    waitIdle();
    expQ = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h64, 8'h3C, 8'h64};
    checkBytes("t5", q1, expQ);

    $display("[TB] uart stall");
    clearQueues();
    @(negedge clk);
    holdLow = 1'b1;
    applyStimulus(3'd3, 7'd7, 7'h7F, 4'd3, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("t6_no_pulse", q1.size(), 0);
    checkOutput("t6_data_held", outData, 8'hB3);
    checkOutput("t6_busy", busy, 1);
    holdLow = 1'b0;
    waitIdle();
    expQ = '{8'hB3, 8'h07, 8'h7F};
    checkBytes("t6", q1, expQ);

    $display("[TB] reset mid-message");
    clearQueues();
    applyStimulus(3'd1, 7'h40, 7'h50, 4'd1, 1'b1);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("t7_rst_send", sendByte, 0);
    checkOutput("t7_rst_busy", busy, 0);
    checkOutput("t7_rst_ready", evReady, 1);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (15) @(negedge clk);
    expQ = '{8'h91};
    checkBytes("t7_abort", q1, expQ);
    applyStimulus(3'd1, 7'h40, 7'h50, 4'd1, 1'b1);
    waitIdle();
    expQ = '{8'h91, 8'h91, 8'h40, 8'h50};
    checkBytes("t7_resend", q1, expQ);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
